// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state codes, pc_sel codes,
// timeout timer width and the decoded-control bundle.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JABS = 2'b10;
  localparam logic [1:0] PC_JREG = 2'b11;

  // Wide enough for any timeout in 1..255.
  localparam int TMR_W = 8;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch_bneq;
    logic branch_bgtz;
    logic jump_abs;
    logic jump_reg;
    logic mtsr_write;
    logic halt;
  } ctrl_t;

  function automatic logic [1:0] pc_sel_f(input ctrl_t c, input logic ne, input logic gtz);
    logic taken;
    taken = (c.branch_bneq & ne) | (c.branch_bgtz & gtz);
    if (c.jump_reg)      return PC_JREG;
    else if (c.jump_abs) return PC_JABS;
    else if (taken)      return PC_BR;
    else                 return PC_INC;
  endfunction

endpackage

// File: rtl/cpu_sequencer_timeout_timer.sv
// Bus-wait timer shared by the FETCH and MEM handshakes; expired flags the last
// permitted waiting cycle so the caller can still let a same-cycle ack win.
module seq_timeout_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (i_clear)    r_cnt <= '0;
    else if (i_count_en) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = i_count_en && (r_cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with imem/dmem req/ack handshakes,
// bus timeout to a sticky ERROR state and a wrapping retired-instruction counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ack,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_branch_bneq,
  input  logic             i_branch_bgtz,
  input  logic             i_jump_abs,
  input  logic             i_jump_reg,
  input  logic             i_mtsr_write,
  input  logic             i_halt,
  input  logic             i_cond_ne,
  input  logic             i_cond_gtz,
  output logic             o_ir_en,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_sel,
  output logic             o_rf_we,
  output logic             o_sr_we,
  output logic             o_halted,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [2:0]       o_state
);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_tmr_en;
  logic             w_tmr_exp;
  ctrl_t            w_c;

  assign w_c = '{reg_write: i_reg_write, mem_read: i_mem_read, mem_write: i_mem_write,
                 branch_bneq: i_branch_bneq, branch_bgtz: i_branch_bgtz,
                 jump_abs: i_jump_abs, jump_reg: i_jump_reg,
                 mtsr_write: i_mtsr_write, halt: i_halt};

  assign w_tmr_en = ((r_state == S_FETCH) && !i_imem_ack) ||
                    ((r_state == S_MEM)   && !i_dmem_ack);

  seq_timeout_timer #(.TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_nxt != r_state),
    .i_count_en (w_tmr_en),
    .o_expired  (w_tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_retire   = 1'b0;
    o_imem_req = 1'b0;
    o_ir_en    = 1'b0;
    o_pc_en    = 1'b0;
    o_pc_sel   = PC_INC;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_sr_we    = 1'b0;
    o_halted   = 1'b0;
    o_bus_err  = 1'b0;
    case (r_state)
      S_IDLE: if (i_run) w_nxt = S_FETCH;
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_en    = i_imem_ack;
        if (i_imem_ack)     w_nxt = S_DECODE;
        else if (w_tmr_exp) w_nxt = S_ERROR;
      end
      S_DECODE: w_nxt = w_c.halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        o_pc_en  = 1'b1;
        o_pc_sel = pc_sel_f(w_c, i_cond_ne, i_cond_gtz);
        if (w_c.mem_read || w_c.mem_write)        w_nxt = S_MEM;
        else if (w_c.reg_write || w_c.mtsr_write) w_nxt = S_WB;
        else                                      w_retire = 1'b1;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = w_c.mem_write;
        if (i_dmem_ack) begin
          if (w_c.mem_read) w_nxt = S_WB;
          else              w_retire = 1'b1;
        end else if (w_tmr_exp) begin
          w_nxt = S_ERROR;
        end
      end
      S_WB: begin
        o_rf_we  = w_c.reg_write;
        o_sr_we  = w_c.mtsr_write;
        w_retire = 1'b1;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (!i_run) w_nxt = S_IDLE;
      end
      S_ERROR: o_bus_err = 1'b1;
      default: w_nxt = S_IDLE;
    endcase
    // Retire point: continue straight into the next fetch or park in IDLE.
    if (w_retire) w_nxt = i_run ? S_FETCH : S_IDLE;
  end

  assign o_instr_count = r_cnt;
  assign o_state       = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: hand table of instructions, hand corner sequences, then random
// instructions whose cycle-by-cycle expectations come from an instruction-level model.
module tb_cpu_sequencer;
  localparam int T     = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic rw, rd, wr, bneq, bgtz, ja, jr, mtsr, halt;
  } ic_t;

  typedef struct {
    ic_t        c;
    logic       ne, gz;
    int         idly, ddly;
    logic [1:0] psel;
    bit         mem, wb, run_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, run, iack, dack, cne, cgtz;
  ic_t  c;
  logic o_imem_req, o_dmem_req, o_dmem_we, o_ir_en, o_pc_en, o_rf_we, o_sr_we, o_halted, o_bus_err;
  logic [1:0]       o_pc_sel;
  logic [CNT_W-1:0] o_instr_count;
  logic [2:0]       o_state;

  logic [CNT_W-1:0] exp_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run),
    .o_imem_req(o_imem_req), .i_imem_ack(iack),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(dack),
    .i_reg_write(c.rw), .i_mem_read(c.rd), .i_mem_write(c.wr),
    .i_branch_bneq(c.bneq), .i_branch_bgtz(c.bgtz),
    .i_jump_abs(c.ja), .i_jump_reg(c.jr), .i_mtsr_write(c.mtsr), .i_halt(c.halt),
    .i_cond_ne(cne), .i_cond_gtz(cgtz),
    .o_ir_en(o_ir_en), .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel),
    .o_rf_we(o_rf_we), .o_sr_we(o_sr_we), .o_halted(o_halted), .o_bus_err(o_bus_err),
    .o_instr_count(o_instr_count), .o_state(o_state)
  );

  function automatic ic_t mkc(input logic rw, rd, wr, bneq, bgtz, ja, jr, mtsr, halt);
    ic_t r;
    r = '{rw, rd, wr, bneq, bgtz, ja, jr, mtsr, halt};
    return r;
  endfunction

  // {imem_req, ir_en, pc_en, pc_sel[1:0], dmem_req, dmem_we, rf_we, sr_we, halted, bus_err}
  function automatic logic [10:0] ov(input logic ireq, iren, pcen, input logic [1:0] ps,
                                     input logic dreq, dwe, rfw, srw, hlt, berr);
    return {ireq, iren, pcen, ps, dreq, dwe, rfw, srw, hlt, berr};
  endfunction

  function automatic logic nz();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] outs();
    return {o_imem_req, o_ir_en, o_pc_en, o_pc_sel, o_dmem_req, o_dmem_we,
            o_rf_we, o_sr_we, o_halted, o_bus_err};
  endfunction

  task automatic chk(input logic [10:0] exp, input string nm);
    n_cmp++;
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL %s outs: got %b want %b", nm, outs(), exp);
    end
    n_cmp++;
    if (o_instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s count: got %0d want %0d", nm, o_instr_count, exp_cnt);
    end
  endtask

  // One clock: drive acks, check at the falling edge, return just after the rising edge.
  task automatic step(input logic ia, input logic da, input logic [10:0] exp, input string nm);
    iack = ia;
    dack = da;
    @(negedge clk);
    chk(exp, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    run   = 1'b0;
    exp_cnt = '0;
    #1;
    chk('0, {nm, "/rst_async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;
    step(nz(), nz(), '0, {nm, "/idle"});
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH again.
  task automatic do_instr(input ic_t ci, input logic ne, gz, input int idly, ddly,
                          input logic [1:0] psel, input bit mem, wb, run_after, input string nm);
    c = ci; cne = ne; cgtz = gz;
    for (int k = 0; k <= idly; k++)
      step(k == idly, nz(), ov(1, k == idly, 0, 0, 0, 0, 0, 0, 0, 0), {nm, "/fetch"});
    if (!mem) run = run_after;
    step(nz(), nz(), '0, {nm, "/decode"});
    step(nz(), nz(), ov(0, 0, 1, psel, 0, 0, 0, 0, 0, 0), {nm, "/exec"});
    if (!mem && !wb) exp_cnt++;
    if (mem) begin
      run = run_after;
      for (int k = 0; k <= ddly; k++) begin
        step(nz(), k == ddly, ov(0, 0, 0, 0, 1, ci.wr, 0, 0, 0, 0), {nm, "/mem"});
        if (k == ddly && !wb) exp_cnt++;
      end
    end
    if (wb) begin
      step(nz(), nz(), ov(0, 0, 0, 0, 0, 0, ci.rw, ci.mtsr, 0, 0), {nm, "/wb"});
      exp_cnt++;
    end
    if (!run_after) begin
      run = 1'b1;
      step(nz(), nz(), '0, {nm, "/idle"});
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{mkc(1,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 2'b00, 0, 1, 1};  // ALU op
    tbl[1]  = '{mkc(0,0,0,1,0,0,0,0,0), 1, 0, 0, 0, 2'b01, 0, 0, 1};  // bneq taken
    tbl[2]  = '{mkc(0,0,0,1,0,0,0,0,0), 0, 1, 1, 0, 2'b00, 0, 0, 1};  // bneq not taken
    tbl[3]  = '{mkc(0,0,0,0,1,0,0,0,0), 0, 1, 0, 0, 2'b01, 0, 0, 1};  // bgtz taken
    tbl[4]  = '{mkc(0,0,0,0,1,0,0,0,0), 1, 0, 0, 0, 2'b00, 0, 0, 1};  // bgtz not taken
    tbl[5]  = '{mkc(0,0,0,0,0,1,1,0,0), 0, 0, 0, 0, 2'b11, 0, 0, 1};  // jr beats ja
    tbl[6]  = '{mkc(0,0,0,1,0,1,0,0,0), 1, 0, 2, 0, 2'b10, 0, 0, 1};  // ja beats branch
    tbl[7]  = '{mkc(1,1,0,0,0,0,0,0,0), 0, 0, 0, 3, 2'b00, 1, 1, 1};  // load, ack after 3
    tbl[8]  = '{mkc(0,0,1,0,0,0,0,0,0), 0, 0, 0, 1, 2'b00, 1, 0, 1};  // store
    tbl[9]  = '{mkc(1,0,1,0,0,0,0,0,0), 0, 0, 0, 0, 2'b00, 1, 0, 1};  // store ignores rw
    tbl[10] = '{mkc(0,0,0,0,0,0,0,1,0), 0, 0, 0, 0, 2'b00, 0, 1, 1};  // mtsr
    tbl[11] = '{mkc(1,0,0,0,0,0,0,0,0), 0, 0, 3, 0, 2'b00, 0, 1, 1};  // ack in expiry cycle
    tbl[12] = '{mkc(1,1,0,0,0,0,0,0,0), 0, 0, 0, 2, 2'b00, 1, 1, 0};  // run=0 during MEM
    tbl[13] = '{mkc(0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 2'b00, 0, 0, 0};  // nop, run=0
    c = '0; cne = 0; cgtz = 0; iack = 0; dack = 0; run = 0; rst_n = 0; exp_cnt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk('0, "reset");
    rst_n = 1'b1;
    step(1, 1, '0, "idle_run0");
    run = 1'b1;
    step(1, 1, '0, "idle_go");

    foreach (tbl[i])
      do_instr(tbl[i].c, tbl[i].ne, tbl[i].gz, tbl[i].idly, tbl[i].ddly, tbl[i].psel,
               tbl[i].mem, tbl[i].wb, tbl[i].run_after, $sformatf("tbl%0d", i));

    // halt: parks in HALT, not retired, leaves on run=0
    c = mkc(0,0,0,0,0,0,0,0,1);
    step(1, 0, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "halt/fetch");
    step(0, 0, '0, "halt/decode");
    step(1, 1, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt/hold0");
    step(1, 1, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt/hold1");
    run = 1'b0;
    step(0, 0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt/run0");
    run = 1'b1;
    step(0, 0, '0, "halt/idle");

    // random instructions vs. instruction-level model
    for (int n = 0; n < 40; n++) begin
      ic_t        rc;
      logic       rne, rgz;
      logic [1:0] ps;
      bit         m, w;
      rc = ic_t'($urandom_range(0, 511));
      rc.halt = 1'b0;
      rne = nz();
      rgz = nz();
      ps = rc.jr ? 2'b11 : rc.ja ? 2'b10 :
           ((rc.bneq && rne) || (rc.bgtz && rgz)) ? 2'b01 : 2'b00;
      m  = rc.rd || rc.wr;
      w  = m ? rc.rd : (rc.rw || rc.mtsr);
      do_instr(rc, rne, rgz, $urandom_range(0, T-1), $urandom_range(0, T-1), ps, m, w,
               $urandom_range(0, 4) != 0, $sformatf("rnd%0d", n));
    end

    // reset while a data request is in flight
    c = mkc(1,1,0,0,0,0,0,0,0);
    step(1, 0, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "mrst/fetch");
    step(0, 0, '0, "mrst/decode");
    step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "mrst/exec");
    dack = 1'b0;
    #1;
    chk(ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "mrst/mem");
    do_reset("mrst");

    // fetch timeout: T cycles of req without ack -> sticky ERROR
    c = mkc(1,0,0,0,0,0,0,0,0);
    for (int k = 0; k < T; k++)
      step(0, 1, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ito/fetch");
    for (int k = 0; k < 3; k++) begin
      run = nz();
      step(1, 1, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ito/error");
    end
    do_reset("ito");

    // data timeout
    c = mkc(0,1,0,0,0,0,0,0,0);
    step(1, 0, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "dto/fetch");
    step(0, 0, '0, "dto/decode");
    step(0, 0, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "dto/exec");
    for (int k = 0; k < T; k++)
      step(1, 0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "dto/mem");
    step(1, 1, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "dto/error");
    do_reset("dto");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
